simple_adder_core: RTL and testbench
====================================

SIMPLE_ADDER_CORE -- requirements
Module: simple_adder

Interface
REQ-001 The parameter list SHALL be exactly as follows.
- WIDTH, 1, operand and sum width in bits; legal range 1..32.
- CNT_W, 16, width of the transaction counter.

REQ-002 The ports SHALL be exactly as follows. Clock and reset are listed first. The block has one clock; reset is asynchronous and active-low.
- clk  input  1  single rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; tie to 0 for plain a+b.
- in_valid  input  1  operands are valid this cycle.
- clr  input  1  synchronous clear of the sticky flag and the counter.
- sum  output  WIDTH  combinational (a+b+cin) mod 2^WIDTH.
- cout  output  1  combinational carry-out of a+b+cin.
- sum_q  output  WIDTH  registered sum.
- cout_q  output  1  registered carry-out.
- out_valid  output  1  sum_q and cout_q hold a fresh result.
- ovf_sticky  output  1  set by any accepted add with a carry-out.
- txn_cnt  output  CNT_W  count of accepted adds.

Function
REQ-003 sum and cout SHALL be purely combinational from a, b and cin, with zero latency, and SHALL be independent of clk, rst_n and in_valid.
REQ-004 With WIDTH=1 and cin=0, sum SHALL equal a XOR b and cout SHALL equal a AND b.
REQ-005 {cout,sum} SHALL equal the (WIDTH+1)-bit result of zero-extended a + b + cin, with no saturation.
REQ-006 On a rising clk edge with in_valid=1, sum_q and cout_q SHALL load the current sum and cout, and out_valid SHALL be 1 in the following cycle (1-cycle latency).
REQ-007 On a rising clk edge with in_valid=0, sum_q and cout_q SHALL hold their values and out_valid SHALL be 0 in the following cycle.
REQ-008 out_valid SHALL be a single-cycle pulse per accepted add; back-to-back in_valid SHALL give back-to-back out_valid, with throughput of one add per cycle and no backpressure.
REQ-009 On an accepted add with cout=1, ovf_sticky SHALL be set to 1 and SHALL stay 1 until clr or reset.
REQ-010 On each accepted add, txn_cnt SHALL increment by 1 and SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-011 When clr=1 at a rising edge, ovf_sticky and txn_cnt SHALL be 0 after that edge. If in_valid=1 on the same edge, clr SHALL take priority for ovf_sticky and txn_cnt, while sum_q, cout_q and out_valid SHALL still update per REQ-006.
REQ-012 Inputs that are X or Z while in_valid=0 SHALL NOT affect any registered output.

Reset
REQ-013 rst_n=0 SHALL immediately, without waiting for a clock edge, force sum_q=0, cout_q=0, out_valid=0, ovf_sticky=0 and txn_cnt=0.
REQ-014 While rst_n=0, all registered outputs SHALL hold 0 and in_valid and clr SHALL be ignored; sum and cout SHALL remain combinationally active.
REQ-015 Reset asserted mid-operation SHALL drop any pending out_valid pulse. The first rising edge with rst_n=1 after deassertion SHALL behave as a normal cycle.

Verification
REQ-016 Exhaustive test with WIDTH=1 and cin=0: apply (a,b)=00,01,10,11 -> sum=0,1,1,0 and cout=0,0,0,1, checked at each following rising edge.
REQ-017 Corner order test with WIDTH=1: apply 00, 11, 01, 10 -> sum=0,0,1,1, with no stale values between steps.
REQ-018 Pipeline test with WIDTH=4: in_valid=1 with a=9, b=8, cin=1 -> sum=2 and cout=1 immediately; one cycle later sum_q=2, cout_q=1, out_valid=1 and ovf_sticky=1.
REQ-019 Hold and count test: issue 3 accepted adds, then 2 idle cycles -> txn_cnt=3, out_valid=0 in the idle cycles, and sum_q holding the last result.
REQ-020 Clear and wrap test with CNT_W=2: issue 4 adds -> txn_cnt wraps to 0; clr together with an overflowing add -> ovf_sticky=0 and txn_cnt=0, while sum_q and cout_q still update.
REQ-021 Async reset test: drive rst_n low between clock edges with out_valid=1 -> all registered outputs are 0 at once, and sum still tracks a XOR b.

Source files
------------

// File: rtl/simple_adder_core.sv
// Combinational adder with a registered result stage, a sticky carry-out flag
// and a wrapping transaction counter.
module simple_adder_core #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             out_valid,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] txn_cnt
);

    logic [WIDTH:0]   full_sum;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             out_valid_d;
    logic             out_valid_q;
    logic             ovf_sticky_d;
    logic             ovf_sticky_q;
    logic [CNT_W-1:0] txn_cnt_d;
    logic [CNT_W-1:0] txn_cnt_q;

    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sum      = full_sum[WIDTH-1:0];
        cout     = full_sum[WIDTH];
    end

    // Result registers only move on accepted adds; clr overrides the flag and
    // counter but never blocks the result path.
    always_comb begin
        sum_d        = sum_q;
        cout_d       = cout_q;
        out_valid_d  = in_valid;
        ovf_sticky_d = ovf_sticky_q;
        txn_cnt_d    = txn_cnt_q;
        if (in_valid) begin
            sum_d        = sum;
            cout_d       = cout;
            ovf_sticky_d = ovf_sticky_q | cout;
            txn_cnt_d    = txn_cnt_q + CNT_W'(1);
        end
        if (clr) begin
            ovf_sticky_d = 1'b0;
            txn_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q        <= '0;
            cout_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            ovf_sticky_q <= 1'b0;
            txn_cnt_q    <= '0;
        end else begin
            sum_q        <= sum_d;
            cout_q       <= cout_d;
            out_valid_q  <= out_valid_d;
            ovf_sticky_q <= ovf_sticky_d;
            txn_cnt_q    <= txn_cnt_d;
        end
    end

    always_comb begin
        out_valid  = out_valid_q;
        ovf_sticky = ovf_sticky_q;
        txn_cnt    = txn_cnt_q;
    end

endmodule

// File: tb/tb_simple_adder_core.sv
// Bench for simple_adder_core: three widths side by side, hand vectors for the
// corner cases and a randomized run against an arithmetic reference model.
module tb_simple_adder_core;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, clr, cin;
    logic [0:0]  a1, b1, s1, sq1;
    logic [3:0]  a4, b4, s4, sq4;
    logic [31:0] a32, b32, s32, sq32;
    logic        c1, cq1, os1, ov1;
    logic        c4, cq4, os4, ov4;
    logic        c32, cq32, os32, ov32;
    logic [15:0] tc1, tc32;
    logic [1:0]  tc4;

    always #5 clk = ~clk;

    simple_adder_core #(.WIDTH(1), .CNT_W(16)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin), .in_valid(in_valid), .clr(clr),
        .sum(s1), .cout(c1), .sum_q(sq1), .cout_q(cq1), .out_valid(os1),
        .ovf_sticky(ov1), .txn_cnt(tc1));

    simple_adder_core #(.WIDTH(4), .CNT_W(2)) u_w4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin), .in_valid(in_valid), .clr(clr),
        .sum(s4), .cout(c4), .sum_q(sq4), .cout_q(cq4), .out_valid(os4),
        .ovf_sticky(ov4), .txn_cnt(tc4));

    simple_adder_core #(.WIDTH(32), .CNT_W(16)) u_w32 (
        .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .cin(cin), .in_valid(in_valid), .clr(clr),
        .sum(s32), .cout(c32), .sum_q(sq32), .cout_q(cq32), .out_valid(os32),
        .ovf_sticky(ov32), .txn_cnt(tc32));

    typedef struct {
        longint unsigned sum;
        bit              cout;
        bit              vld;
        bit              ovf;
        longint unsigned cnt;
    } mstate_t;

    typedef struct {
        bit a;
        bit b;
        bit s;
        bit c;
    } vec1_t;

    mstate_t     m [3];
    int unsigned wid [3] = '{1, 4, 32};
    int unsigned cw  [3] = '{16, 2, 16};
    int          errors = 0;
    int          checks = 0;

    function automatic longint unsigned opa(int unsigned i);
        case (i)
            0:       return longint'(a1);
            1:       return longint'(a4);
            default: return longint'(a32);
        endcase
    endfunction

    function automatic longint unsigned opb(int unsigned i);
        case (i)
            0:       return longint'(b1);
            1:       return longint'(b4);
            default: return longint'(b32);
        endcase
    endfunction

    function automatic longint unsigned total(int unsigned i);
        return opa(i) + opb(i) + longint'(cin);
    endfunction

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int unsigned i = 0; i < 3; i++) m[i] = '{default: 0};
    endtask

    // Reference behaviour at a rising edge, expressed as plain arithmetic.
    task automatic model_edge();
        longint unsigned t;
        for (int unsigned i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m[i] = '{default: 0};
            end else begin
                t = total(i);
                m[i].vld = in_valid;
                if (in_valid) begin
                    m[i].sum = t % (64'd1 << wid[i]);
                    m[i].cout = (t >> wid[i]) != 0;
                end
                if (clr) begin
                    m[i].ovf = 0;
                    m[i].cnt = 0;
                end else if (in_valid) begin
                    m[i].ovf = m[i].ovf | m[i].cout;
                    m[i].cnt = (m[i].cnt + 1) % (64'd1 << cw[i]);
                end
            end
        end
    endtask

    task automatic check_inst(input int unsigned i, input longint unsigned sq, input longint unsigned cq,
                              input longint unsigned os, input longint unsigned ov, input longint unsigned tc);
        chk($sformatf("w%0d sum_q", wid[i]), sq, m[i].sum);
        chk($sformatf("w%0d cout_q", wid[i]), cq, longint'(m[i].cout));
        chk($sformatf("w%0d out_valid", wid[i]), os, longint'(m[i].vld));
        chk($sformatf("w%0d ovf_sticky", wid[i]), ov, longint'(m[i].ovf));
        chk($sformatf("w%0d txn_cnt", wid[i]), tc, m[i].cnt);
    endtask

    task automatic check_regs();
        check_inst(0, longint'(sq1), longint'(cq1), longint'(os1), longint'(ov1), longint'(tc1));
        check_inst(1, longint'(sq4), longint'(cq4), longint'(os4), longint'(ov4), longint'(tc4));
        check_inst(2, longint'(sq32), longint'(cq32), longint'(os32), longint'(ov32), longint'(tc32));
    endtask

    task automatic check_comb_inst(input int unsigned i, input longint unsigned s, input longint unsigned c);
        longint unsigned t;
        t = total(i);
        chk($sformatf("w%0d sum", wid[i]), s, t % (64'd1 << wid[i]));
        chk($sformatf("w%0d cout", wid[i]), c, t >> wid[i]);
    endtask

    task automatic check_comb();
        check_comb_inst(0, longint'(s1), longint'(c1));
        check_comb_inst(1, longint'(s4), longint'(c4));
        check_comb_inst(2, longint'(s32), longint'(c32));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    vec1_t tbl [8];

    initial begin
        // Exhaustive order, then corner order.
        tbl[0] = '{a: 0, b: 0, s: 0, c: 0};
        tbl[1] = '{a: 0, b: 1, s: 1, c: 0};
        tbl[2] = '{a: 1, b: 0, s: 1, c: 0};
        tbl[3] = '{a: 1, b: 1, s: 0, c: 1};
        tbl[4] = '{a: 0, b: 0, s: 0, c: 0};
        tbl[5] = '{a: 1, b: 1, s: 0, c: 1};
        tbl[6] = '{a: 0, b: 1, s: 1, c: 0};
        tbl[7] = '{a: 1, b: 0, s: 1, c: 0};

        rst_n = 1'b0; in_valid = 1'b1; clr = 1'b0; cin = 1'b0;
        a1 = '0; b1 = '0; a4 = '0; b4 = '0; a32 = '0; b32 = '0;
        model_reset();
        #3;
        check_regs();
        cycle();
        cycle();
        rst_n = 1'b1;
        in_valid = 1'b0;
        cycle();

        for (int unsigned i = 0; i < 8; i++) begin
            a1 = tbl[i].a; b1 = tbl[i].b; cin = 1'b0; in_valid = 1'b1;
            #1;
            chk("tbl sum", longint'(s1), longint'(tbl[i].s));
            chk("tbl cout", longint'(c1), longint'(tbl[i].c));
            check_comb();
            cycle();
            chk("tbl sum_q", longint'(sq1), longint'(tbl[i].s));
            chk("tbl cout_q", longint'(cq1), longint'(tbl[i].c));
        end

        a1 = '0; b1 = '0; a4 = 4'd9; b4 = 4'd8; cin = 1'b1;
        a32 = 32'hFFFF_FFFF; b32 = '0; in_valid = 1'b1;
        #1;
        chk("pipe sum", longint'(s4), 2);
        chk("pipe cout", longint'(c4), 1);
        check_comb();
        cycle();
        chk("pipe sum_q", longint'(sq4), 2);
        chk("pipe cout_q", longint'(cq4), 1);
        chk("pipe out_valid", longint'(os4), 1);
        chk("pipe ovf", longint'(ov4), 1);
        chk("w32 max sum_q", longint'(sq32), 0);

        in_valid = 1'b0; clr = 1'b1; cin = 1'b0;
        cycle();
        clr = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            a4 = 4'(k + 5); b4 = 4'(k + 10); in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0; a4 = 4'd1; b4 = 4'd1;
        for (int unsigned k = 0; k < 2; k++) begin
            cycle();
            chk("hold out_valid", longint'(os4), 0);
            chk("hold sum_q", longint'(sq4), 3);
            chk("hold cout_q", longint'(cq4), 1);
        end
        chk("hold txn_cnt w4", longint'(tc4), 3);
        chk("hold txn_cnt w1", longint'(tc1), 3);

        in_valid = 1'b1;
        cycle();
        chk("wrap txn_cnt", longint'(tc4), 0);
        chk("wrap ovf", longint'(ov4), 1);
        clr = 1'b1; a4 = 4'd15; b4 = 4'd3;
        cycle();
        chk("clr ovf", longint'(ov4), 0);
        chk("clr txn_cnt", longint'(tc4), 0);
        chk("clr sum_q", longint'(sq4), 2);
        chk("clr cout_q", longint'(cq4), 1);
        chk("clr out_valid", longint'(os4), 1);
        clr = 1'b0; in_valid = 1'b0;

        for (int unsigned n = 0; n < 300; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            clr      = ($urandom_range(0, 15) == 0);
            cin      = 1'($urandom_range(0, 1));
            a1  = 1'($urandom_range(0, 1));  b1  = 1'($urandom_range(0, 1));
            a4  = 4'($urandom_range(0, 15)); b4  = 4'($urandom_range(0, 15));
            a32 = $urandom;                  b32 = $urandom;
            #1;
            check_comb();
            cycle();
        end

        in_valid = 1'b1; clr = 1'b0; cin = 1'b0; a1 = 1'b1; b1 = 1'b0;
        cycle();
        chk("pre-rst out_valid", longint'(os1), 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs();
        chk("rst comb sum", longint'(s1), 1);
        a1 = 1'b1; b1 = 1'b1;
        #1;
        chk("rst comb sum 11", longint'(s1), 0);
        chk("rst comb cout 11", longint'(c1), 1);
        cycle();
        #2;
        rst_n = 1'b1;
        cycle();
        chk("post-rst out_valid", longint'(os1), 1);
        chk("post-rst txn_cnt", longint'(tc1), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
